// File: rtl/alu_seq_pkg.sv
// Shared definitions for the nibble-serial ALU sequencer: function codes, FSM states, default width.
// The RUN2 state only exists when ALU_SEQ_EAC_EN is defined.
package alu_seq_pkg;

    localparam int NIBBLES_DEFAULT = 4;

    localparam logic [2:0] FN_ADD   = 3'd0;
    localparam logic [2:0] FN_AND   = 3'd1;
    localparam logic [2:0] FN_OR    = 3'd2;
    localparam logic [2:0] FN_XOR   = 3'd3;
    localparam logic [2:0] FN_PASSA = 3'd4;
    localparam logic [2:0] FN_PASSB = 3'd5;
    localparam logic [2:0] FN_SHR   = 3'd6;
    localparam logic [2:0] FN_SHL   = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
`ifdef ALU_SEQ_EAC_EN
        , RUN2 = 2'd3
`endif
    } state_t;

endpackage

// File: rtl/alu_nibble_sequencer.sv
// Drives an external 4-bit ALU slice one nibble per clock to build a 4*NIBBLES-bit result and flags.
// Define ALU_SEQ_EAC_EN to add an end-around-carry second pass for ADD.
module alu_nibble_sequencer
    import alu_seq_pkg::*;
#(
    parameter int NIBBLES = NIBBLES_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [2:0]             func,
    input  logic                   com,
    input  logic                   cin,
    input  logic [4*NIBBLES-1:0]   op_a,
    input  logic [4*NIBBLES-1:0]   op_b,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   result,
    output logic                   cout,
    output logic                   zero,
    output logic                   neg_zero,
    output logic                   equal,
    output logic [3:0]             slice_a,
    output logic [3:0]             slice_b,
    output logic [2:0]             slice_f,
    output logic                   slice_com,
    output logic                   slice_ci_right,
    output logic                   slice_ci_left,
    input  logic [3:0]             slice_d,
    input  logic                   slice_co_left,
    input  logic                   slice_co_right,
    input  logic                   slice_zero,
    input  logic                   slice_neg_zero,
    input  logic                   slice_equ
);

    localparam int W  = 4 * NIBBLES;
    localparam int IW = 3;

    state_t          state;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [2:0]      func_q;
    logic            com_q;
    logic            cin_q;
    logic [IW-1:0]   idx;
    logic            carry_q;
    logic            zero_acc;
    logic            neg_acc;
    logic            equ_acc;

    logic            running;
    logic            pass2;
    logic            shr_mode;
    logic            last;
    logic [IW-1:0]   pos;
    logic [IW+1:0]   sh;
    logic            chain_in;
    logic            co_sel;
    logic            cout_last;
    logic [W-1:0]    nib_mask;

    assign slice_f   = func_q;
    assign slice_com = com_q;

    // SHR walks from the MSB nibble down so the shift-in ripples rightwards.
    always_comb begin
        running   = (state == RUN);
        pass2     = 1'b0;
`ifdef ALU_SEQ_EAC_EN
        running   = (state == RUN) || (state == RUN2);
        pass2     = (state == RUN2);
`endif
        shr_mode  = (func_q == FN_SHR);
        last      = (idx == IW'(NIBBLES - 1));
        pos       = shr_mode ? (IW'(NIBBLES - 1) - idx) : idx;
        sh        = {pos, 2'b00};
        nib_mask  = W'(4'hF) << sh;
        chain_in  = (idx == '0) ? (pass2 | cin_q) : carry_q;
        co_sel    = shr_mode ? slice_co_right : slice_co_left;
        cout_last = 1'b0;
        case (func_q)
            FN_ADD, FN_SHL: cout_last = slice_co_left;
            FN_SHR:         cout_last = slice_co_right;
            default:        cout_last = 1'b0;
        endcase

        slice_a        = 4'h0;
        slice_b        = 4'h0;
        slice_ci_right = 1'b0;
        slice_ci_left  = 1'b0;
        if (running) begin
            slice_a = 4'(a_q >> sh);
            slice_b = 4'(b_q >> sh);
            if (shr_mode) begin
                slice_ci_left = chain_in;
            end else begin
                slice_ci_right = chain_in;
            end
        end
    end

    // done is registered from the DONE state, so it appears one cycle after the last nibble settles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            func_q   <= 3'd0;
            com_q    <= 1'b0;
            cin_q    <= 1'b0;
            idx      <= '0;
            carry_q  <= 1'b0;
            zero_acc <= 1'b0;
            neg_acc  <= 1'b0;
            equ_acc  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            cout     <= 1'b0;
            zero     <= 1'b0;
            neg_zero <= 1'b0;
            equal    <= 1'b0;
        end else begin
            done <= (state == DONE);
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_q      <= op_a;
                        b_q      <= op_b;
                        func_q   <= func;
                        com_q    <= com;
                        cin_q    <= cin;
                        idx      <= '0;
                        zero_acc <= 1'b1;
                        neg_acc  <= 1'b1;
                        equ_acc  <= 1'b1;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    result   <= (result & ~nib_mask) | (W'(slice_d) << sh);
                    zero_acc <= zero_acc & slice_zero;
                    neg_acc  <= neg_acc & slice_neg_zero;
                    equ_acc  <= equ_acc & slice_equ;
                    carry_q  <= co_sel;
                    idx      <= idx + IW'(1);
                    if (last) begin
                        idx <= '0;
`ifdef ALU_SEQ_EAC_EN
                        if (!pass2 && (func_q == FN_ADD) && slice_co_left) begin
                            cout     <= 1'b1;
                            zero_acc <= 1'b1;
                            neg_acc  <= 1'b1;
                            equ_acc  <= 1'b1;
                            state    <= RUN2;
                        end else
`endif
                        begin
                            zero     <= zero_acc & slice_zero;
                            neg_zero <= neg_acc & slice_neg_zero;
                            equal    <= equ_acc & slice_equ;
                            // A second pass keeps the first-pass carry already in cout.
                            if (!pass2) begin
                                cout <= cout_last;
                            end
                            busy  <= 1'b0;
                            state <= DONE;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Self-checking bench: sequencer paired with a behavioural 4-bit slice, scoreboard of whole-word results.
// Expectations follow ALU_SEQ_EAC_EN when it is defined for the build.
module tb_alu_nibble_sequencer;
    import alu_seq_pkg::*;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [2:0]     func;
    logic           com;
    logic           cin;
    logic [W-1:0]   op_a;
    logic [W-1:0]   op_b;
    logic           busy;
    logic           done;
    logic [W-1:0]   result;
    logic           cout;
    logic           zero;
    logic           neg_zero;
    logic           equal;
    logic [3:0]     slice_a;
    logic [3:0]     slice_b;
    logic [2:0]     slice_f;
    logic           slice_com;
    logic           slice_ci_right;
    logic           slice_ci_left;
    logic [3:0]     slice_d;
    logic           slice_co_left;
    logic           slice_co_right;
    logic           slice_zero;
    logic           slice_neg_zero;
    logic           slice_equ;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   f;
        logic         com;
        logic         cin;
        logic [W-1:0] res;
        logic         cout;
        logic         zero;
        logic         neg;
        logic         equ;
        logic [7:0]   lat;
    } exp_t;

    exp_t sb[$];

    alu_nibble_sequencer #(.NIBBLES(N)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .func(func), .com(com), .cin(cin),
        .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .result(result),
        .cout(cout), .zero(zero), .neg_zero(neg_zero), .equal(equal),
        .slice_a(slice_a), .slice_b(slice_b), .slice_f(slice_f), .slice_com(slice_com),
        .slice_ci_right(slice_ci_right), .slice_ci_left(slice_ci_left),
        .slice_d(slice_d), .slice_co_left(slice_co_left), .slice_co_right(slice_co_right),
        .slice_zero(slice_zero), .slice_neg_zero(slice_neg_zero), .slice_equ(slice_equ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 4-bit slice: carries come from the raw result, flags from the driven nibble.
    logic [3:0] s_raw;
    logic [4:0] s_sum;
    logic       s_col;
    logic       s_cor;
    always_comb begin
        s_raw = 4'h0;
        s_sum = 5'h0;
        s_col = 1'b0;
        s_cor = 1'b0;
        case (slice_f)
            FN_ADD: begin
                s_sum = {1'b0, slice_a} + {1'b0, slice_b} + {4'h0, slice_ci_right};
                s_raw = s_sum[3:0];
                s_col = s_sum[4];
            end
            FN_AND:   s_raw = slice_a & slice_b;
            FN_OR:    s_raw = slice_a | slice_b;
            FN_XOR:   s_raw = slice_a ^ slice_b;
            FN_PASSA: s_raw = slice_a;
            FN_PASSB: s_raw = slice_b;
            FN_SHR: begin
                s_raw = {slice_ci_left, slice_a[3:1]};
                s_cor = slice_a[0];
            end
            default: begin
                s_raw = {slice_a[2:0], slice_ci_right};
                s_col = slice_a[3];
            end
        endcase
    end
    assign slice_d        = slice_com ? ~s_raw : s_raw;
    assign slice_co_left  = s_col;
    assign slice_co_right = s_cor;
    assign slice_zero     = (slice_d == 4'h0);
    assign slice_neg_zero = (slice_d == 4'hF);
    assign slice_equ      = (slice_a == slice_b);

    // Whole-word reference computed directly on W-bit operands.
    function automatic exp_t make_exp(input logic [2:0] f, input logic c, input logic ci,
                                      input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        logic [W:0]   sum;
        logic [W-1:0] raw;
        logic         co;
        e = '0;
        e.a = a; e.b = b; e.f = f; e.com = c; e.cin = ci;
        e.lat = 8'(N + 1);
        co  = 1'b0;
        raw = '0;
        case (f)
            FN_ADD: begin
                sum = {1'b0, a} + {1'b0, b} + (W+1)'(ci);
                raw = sum[W-1:0];
                co  = sum[W];
`ifdef ALU_SEQ_EAC_EN
                if (co) begin
                    sum   = {1'b0, a} + {1'b0, b} + (W+1)'(1);
                    raw   = sum[W-1:0];
                    e.lat = 8'(2 * N + 1);
                end
`endif
            end
            FN_AND:   raw = a & b;
            FN_OR:    raw = a | b;
            FN_XOR:   raw = a ^ b;
            FN_PASSA: raw = a;
            FN_PASSB: raw = b;
            FN_SHR: begin raw = {ci, a[W-1:1]}; co = a[0]; end
            default: begin raw = {a[W-2:0], ci}; co = a[W-1]; end
        endcase
        e.res  = c ? ~raw : raw;
        e.cout = co;
        e.zero = (e.res == '0);
        e.neg  = (e.res == '1);
        e.equ  = (a == b);
        return e;
    endfunction

    // Expected slice drive for the k-th nibble step (k >= N is the end-around pass).
    function automatic void chain_exp(input exp_t e, input int k, output logic ci_l,
                                      output logic ci_r, output logic [3:0] nib_a);
        int         kk;
        int         pos;
        logic       ci0;
        logic [W:0] m;
        logic [W:0] low;
        kk    = k % N;
        ci0   = (k >= N) ? 1'b1 : e.cin;
        ci_l  = 1'b0;
        ci_r  = 1'b0;
        pos   = (e.f == FN_SHR) ? (N - 1 - kk) : kk;
        nib_a = 4'(e.a >> (4 * pos));
        case (e.f)
            FN_SHR: ci_l = (kk == 0) ? e.cin : e.a[4 * (N - kk)];
            FN_SHL: ci_r = (kk == 0) ? e.cin : e.a[4 * kk - 1];
            FN_ADD: begin
                m    = ((W+1)'(1) << (4 * kk)) - (W+1)'(1);
                low  = ({1'b0, e.a} & m) + ({1'b0, e.b} & m) + (W+1)'(ci0);
                ci_r = (kk == 0) ? ci0 : low[4 * kk];
            end
            default: ;
        endcase
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives one request through the start-sampling edge (edge 0) and queues its expectation.
    task automatic apply_stimulus(input logic [2:0] f, input logic c, input logic ci,
                                  input logic [W-1:0] a, input logic [W-1:0] b, input bit hold);
        sb.push_back(make_exp(f, c, ci, a, b));
        func = f; com = c; cin = ci; op_a = a; op_b = b; start = 1'b1;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
    endtask

    // Entered #1 after edge start_edge of the front operation; follows it to its done pulse.
    task automatic check_output(input string tag, input int start_edge);
        exp_t e;
        int   edge_n;
        bit   seen;
        logic ci_l, ci_r;
        logic [3:0] nib_a;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, W'(1), W'(0));
            return;
        end
        e      = sb[0];
        edge_n = start_edge;
        seen   = 1'b0;
        while (!seen && edge_n < 4 * N + 8) begin
            check($sformatf("%s_busy_e%0d", tag, edge_n), W'(busy), W'(edge_n <= int'(e.lat) - 2));
            if (edge_n <= int'(e.lat) - 2) begin
                chain_exp(e, edge_n, ci_l, ci_r, nib_a);
                check($sformatf("%s_cil_e%0d", tag, edge_n), W'(slice_ci_left), W'(ci_l));
                check($sformatf("%s_cir_e%0d", tag, edge_n), W'(slice_ci_right), W'(ci_r));
                check($sformatf("%s_sa_e%0d", tag, edge_n), W'(slice_a), W'(nib_a));
            end
            @(posedge clk); #1;
            edge_n++;
            seen = done;
        end
        if (!seen) begin
            check({tag, "_timeout"}, W'(done), W'(1));
            void'(sb.pop_front());
            return;
        end
        e = sb.pop_front();
        check({tag, "_lat"},    W'(edge_n),   W'(e.lat));
        check({tag, "_res"},    result,       e.res);
        check({tag, "_cout"},   W'(cout),     W'(e.cout));
        check({tag, "_zero"},   W'(zero),     W'(e.zero));
        check({tag, "_negz"},   W'(neg_zero), W'(e.neg));
        check({tag, "_equal"},  W'(equal),    W'(e.equ));
        check({tag, "_sa_idle"}, W'(slice_a), W'(busy ? slice_a : 4'h0));
        @(posedge clk); #1;
        check({tag, "_done_1cyc"}, W'(done), W'(0));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},   W'(busy), W'(0));
        check({tag, "_done"},   W'(done), W'(0));
        check({tag, "_result"}, result, W'(0));
        check({tag, "_flags"},  W'({cout, zero, neg_zero, equal}), W'(0));
        check({tag, "_slice"},  W'({slice_a, slice_b, slice_f, slice_com, slice_ci_right, slice_ci_left}), W'(0));
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int extra;
        rst_n = 1'b0; start = 1'b0; func = 3'd0; com = 1'b0; cin = 1'b0; op_a = '0; op_b = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("por");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        apply_stimulus(FN_ADD, 1'b0, 1'b0, 16'h1234, 16'h0FCD, 1'b0);
        check_output("add_basic", 0);
        apply_stimulus(FN_ADD, 1'b0, 1'b0, 16'hFFFF, 16'h0001, 1'b0);
        check_output("add_wrap", 0);
        apply_stimulus(FN_ADD, 1'b0, 1'b1, 16'h7A5C, 16'h19E3, 1'b0);
        check_output("add_cin", 0);
        apply_stimulus(FN_SHR, 1'b0, 1'b1, 16'h8001, 16'h0000, 1'b0);
        check_output("shr_8001", 0);
        apply_stimulus(FN_SHR, 1'b0, 1'b0, 16'h1111, 16'h0000, 1'b0);
        check_output("shr_1111", 0);
        apply_stimulus(FN_SHL, 1'b0, 1'b0, 16'h8001, 16'h0000, 1'b0);
        check_output("shl_8001", 0);
        apply_stimulus(FN_SHL, 1'b0, 1'b1, 16'h8888, 16'h0000, 1'b0);
        check_output("shl_8888", 0);
        apply_stimulus(FN_XOR, 1'b1, 1'b0, 16'hA5A5, 16'hA5A5, 1'b0);
        check_output("xor_com", 0);
        apply_stimulus(FN_AND, 1'b0, 1'b0, 16'h00F0, 16'h0F00, 1'b0);
        check_output("and_zero", 0);

        // Start pulsed at edge 2 while busy must be ignored.
        apply_stimulus(FN_OR, 1'b0, 1'b0, 16'h1234, 16'h4321, 1'b0);
        @(posedge clk); #1;
        start = 1'b1; func = FN_SHL; op_a = 16'hFFFF;
        @(posedge clk); #1;
        start = 1'b0;
        check_output("or_ignore", 2);
        extra = 0;
        repeat (N + 3) begin
            @(posedge clk); #1;
            if (done) extra++;
        end
        check("ignored_start_no_done", W'(extra), W'(0));

        // Start held through DONE: second request accepted back-to-back.
        apply_stimulus(FN_PASSA, 1'b0, 1'b0, 16'hBEEF, 16'h0000, 1'b1);
        sb.push_back(make_exp(FN_PASSB, 1'b1, 1'b0, 16'h0000, 16'h1357));
        func = FN_PASSB; com = 1'b1; op_a = 16'h0000; op_b = 16'h1357;
        check_output("b2b_first", 0);
        start = 1'b0;
        check_output("b2b_second", 1);

        // Asynchronous reset in the middle of an ADD.
        apply_stimulus(FN_ADD, 1'b0, 1'b0, 16'h1234, 16'h0FCD, 1'b0);
        @(posedge clk); #1;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midop_rst");
        sb.delete();
        extra = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (done) extra++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (N + 2) begin
            @(posedge clk); #1;
            if (done) extra++;
        end
        check("midop_rst_no_done", W'(extra), W'(0));
        apply_stimulus(FN_SHL, 1'b0, 1'b1, 16'h4321, 16'h0000, 1'b0);
        check_output("after_rst", 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
